// File: rtl/checkpointed_map_table.sv
// rtl/checkpointed_map_table.sv - register rename map table with circular-queue checkpoints
// Optional build macro MAP_TABLE_BYPASS_EN: forwards a same-cycle rename write to matching read ports.
module checkpointed_map_table #(
    parameter int PHYS_ADDR_WIDTH = 7,
    parameter int READ_PORTS      = 2,
    parameter int NUM_CKPTS       = 4,
    parameter int CKPT_ID_WIDTH   = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [READ_PORTS*5-1:0]               rd_arch_addr,
    output logic [READ_PORTS*PHYS_ADDR_WIDTH-1:0] rd_phys_addr,
    input  logic                                  wr_en,
    input  logic [4:0]                            wr_arch_addr,
    input  logic [PHYS_ADDR_WIDTH-1:0]            wr_phys_addr,
    output logic [PHYS_ADDR_WIDTH-1:0]            wr_old_phys,
    input  logic                                  ckpt_req,
    output logic                                  ckpt_ready,
    output logic [CKPT_ID_WIDTH-1:0]              ckpt_id,
    input  logic                                  ckpt_release,
    input  logic                                  restore,
    input  logic [CKPT_ID_WIDTH-1:0]              restore_id,
    output logic [CKPT_ID_WIDTH:0]                ckpt_count
);

    localparam logic [CKPT_ID_WIDTH:0] FULL_COUNT = (CKPT_ID_WIDTH+1)'(NUM_CKPTS);

    // Live speculative map and the snapshot slots
    logic [PHYS_ADDR_WIDTH-1:0] map_q    [32];
    logic [PHYS_ADDR_WIDTH-1:0] map_next [32];
    logic [PHYS_ADDR_WIDTH-1:0] ckpt_mem [NUM_CKPTS][32];

    // Circular-queue bookkeeping: head = oldest live slot, tail = next slot to allocate
    logic [CKPT_ID_WIDTH-1:0] head_q;
    logic [CKPT_ID_WIDTH-1:0] tail_q;
    logic [CKPT_ID_WIDTH:0]   count_q;

    logic [CKPT_ID_WIDTH-1:0] restore_dist;
    logic                     restore_fire;
    logic                     write_fire;
    logic                     alloc_fire;
    logic                     release_fire;
    logic                     full;

    // A restore is honoured only when its slot lies inside the live window; a valid
    // restore then wins over every other same-cycle request
    always_comb begin
        restore_dist = restore_id - head_q;
        full         = (count_q == FULL_COUNT);
        restore_fire = restore && ({1'b0, restore_dist} < count_q);
        write_fire   = wr_en && !restore_fire && (wr_arch_addr != 5'd0);
        alloc_fire   = ckpt_req && !full && !restore_fire;
        release_fire = ckpt_release && (count_q != '0) && !restore_fire;
    end

    // Post-write view of the map; a checkpoint taken this cycle captures this view
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            map_next[i] = map_q[i];
        end
        if (write_fire) begin
            map_next[wr_arch_addr] = wr_phys_addr;
        end
        map_next[0] = '0;
    end

    // Map update: reset to identity, reload from a snapshot, or take the rename write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                map_q[i] <= PHYS_ADDR_WIDTH'(i);
            end
        end else if (restore_fire) begin
            for (int i = 0; i < 32; i++) begin
                map_q[i] <= ckpt_mem[restore_id][i];
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                map_q[i] <= map_next[i];
            end
        end
    end

    // Snapshot capture into the tail slot; slot contents are never cleared since
    // only live slots can ever be read back
    always_ff @(posedge clock) begin
        if (!reset && alloc_fire) begin
            for (int i = 0; i < 32; i++) begin
                ckpt_mem[tail_q][i] <= map_next[i];
            end
        end
    end

    // Queue pointers: a restore truncates the queue at the restored slot, otherwise
    // allocation and release may proceed together in one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (restore_fire) begin
            tail_q  <= restore_id;
            count_q <= {1'b0, restore_dist};
        end else begin
            if (alloc_fire) begin
                tail_q <= tail_q + 1'b1;
            end
            if (release_fire) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + {{CKPT_ID_WIDTH{1'b0}}, alloc_fire}
                               - {{CKPT_ID_WIDTH{1'b0}}, release_fire};
        end
    end

    // Combinational lookup ports; entry 0 is hardwired to zero
    always_comb begin
        for (int k = 0; k < READ_PORTS; k++) begin
            logic [4:0]                 ra;
            logic [PHYS_ADDR_WIDTH-1:0] val;
            ra  = rd_arch_addr[k*5 +: 5];
            val = map_q[ra];
`ifdef MAP_TABLE_BYPASS_EN
            if (write_fire && (ra == wr_arch_addr)) begin
                val = wr_phys_addr;
            end
`else
            val = map_q[ra];
`endif
            if (ra == 5'd0) begin
                val = '0;
            end
            rd_phys_addr[k*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH] = val;
        end
    end

    // Old mapping of the register being renamed, always the pre-write value
    always_comb begin
        wr_old_phys = (wr_arch_addr == 5'd0) ? '0 : map_q[wr_arch_addr];
        ckpt_ready  = !full;
        ckpt_id     = tail_q;
        ckpt_count  = count_q;
    end

endmodule

// File: tb/tb_checkpointed_map_table.sv
// tb/tb_checkpointed_map_table.sv - scoreboard bench for checkpointed_map_table
module tb_checkpointed_map_table;

    localparam int P = 7;
    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  rd_arch_addr = '0;
    logic [13:0] rd_phys_addr;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_arch_addr = '0;
    logic [6:0]  wr_phys_addr = '0;
    logic [6:0]  wr_old_phys;
    logic        ckpt_req = 1'b0;
    logic        ckpt_ready;
    logic [1:0]  ckpt_id;
    logic        ckpt_release = 1'b0;
    logic        restore = 1'b0;
    logic [1:0]  restore_id = '0;
    logic [2:0]  ckpt_count;

    checkpointed_map_table dut (
        .clock        (clock),
        .reset        (reset),
        .rd_arch_addr (rd_arch_addr),
        .rd_phys_addr (rd_phys_addr),
        .wr_en        (wr_en),
        .wr_arch_addr (wr_arch_addr),
        .wr_phys_addr (wr_phys_addr),
        .wr_old_phys  (wr_old_phys),
        .ckpt_req     (ckpt_req),
        .ckpt_ready   (ckpt_ready),
        .ckpt_id      (ckpt_id),
        .ckpt_release (ckpt_release),
        .restore      (restore),
        .restore_id   (restore_id),
        .ckpt_count   (ckpt_count)
    );

    always #5 clock = ~clock;

    typedef int map_t [32];
    typedef struct {
        int rd0;
        int rd1;
        int old;
        int ready;
        int id;
        int cnt;
    } exp_t;

    exp_t expq[$];
    map_t ckq[$];
    map_t mdl_map;
    int   head_id = 0;
    bit   model_valid = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive, predict the outputs seen this cycle, then advance the model
    task automatic step(input bit rs, input int a0, input int a1, input bit we, input int wa,
                        input int wp, input bit cr, input bit cl, input bit rt, input int rid);
        exp_t e;
        int   sz;
        int   idx;
        bit   live;
        bit   wfire;
        bit   do_alloc;
        bit   do_rel;
        @(posedge clock);
        #2;
        reset        = rs;
        rd_arch_addr = {5'(a1), 5'(a0)};
        wr_en        = we;
        wr_arch_addr = 5'(wa);
        wr_phys_addr = 7'(wp);
        ckpt_req     = cr;
        ckpt_release = cl;
        restore      = rt;
        restore_id   = 2'(rid);

        sz    = ckq.size();
        idx   = (rid - head_id + N) % N;
        live  = rt && (idx < sz);
        wfire = we && !live && (wa != 0);
        if (model_valid) begin
            e.rd0 = (a0 == 0) ? 0 : mdl_map[a0];
            e.rd1 = (a1 == 0) ? 0 : mdl_map[a1];
`ifdef MAP_TABLE_BYPASS_EN
            if (wfire && a0 == wa) e.rd0 = wp;
            if (wfire && a1 == wa) e.rd1 = wp;
`endif
            e.old   = (wa == 0) ? 0 : mdl_map[wa];
            e.ready = (sz != N) ? 1 : 0;
            e.id    = (head_id + sz) % N;
            e.cnt   = sz;
            expq.push_back(e);
        end

        if (rs) begin
            for (int i = 0; i < 32; i++) mdl_map[i] = i;
            ckq.delete();
            head_id     = 0;
            model_valid = 1'b1;
        end else if (live) begin
            mdl_map = ckq[idx];
            while (ckq.size() > idx) void'(ckq.pop_back());
        end else begin
            do_alloc = cr && (sz != N);
            do_rel   = cl && (sz != 0);
            if (wfire) mdl_map[wa] = wp;
            if (do_rel) begin
                void'(ckq.pop_front());
                head_id = (head_id + 1) % N;
            end
            if (do_alloc) ckq.push_back(mdl_map);
        end
    endtask

    task automatic idle_read(input int a0, input int a1);
        step(0, a0, a1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle's outputs are compared against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rd_phys_addr[0]", int'(rd_phys_addr[6:0]), e.rd0);
                chk("rd_phys_addr[1]", int'(rd_phys_addr[13:7]), e.rd1);
                chk("wr_old_phys", int'(wr_old_phys), e.old);
                chk("ckpt_ready", int'(ckpt_ready), e.ready);
                chk("ckpt_id", int'(ckpt_id), e.id);
                chk("ckpt_count", int'(ckpt_count), e.cnt);
            end
        end
    end

    initial begin
        int a0, a1, wa;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5, 31, 0, 0, 0, 0, 0, 0, 0);

        // identity after reset, x0 write ignored
        step(0, 5, 31, 1, 0, 40, 0, 0, 0, 0);
        idle_read(0, 5);

        // same-cycle write vs read, then settled value
        step(0, 3, 3, 1, 3, 64, 0, 0, 0, 0);
        idle_read(3, 0);

        // checkpoint captures same-cycle write, restore brings it back
        step(0, 7, 0, 1, 7, 90, 1, 0, 0, 0);
        step(0, 7, 0, 1, 7, 91, 0, 0, 0, 0);
        step(0, 7, 3, 0, 0, 0, 0, 0, 1, 0);
        idle_read(7, 3);

        // fill, refuse, release, wrap
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, i, 9, 1, 9 + i, 100 + i, 1, 0, 0, 0);
        step(0, 9, 10, 0, 0, 0, 1, 1, 0, 0);
        step(0, 9, 10, 0, 0, 0, 0, 1, 0, 0);
        step(0, 9, 10, 0, 0, 0, 1, 0, 0, 0);
        idle_read(11, 12);

        // restore beats same-cycle write and alloc; dead id then ignored
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 20, 21, 1, 20 + i, 50 + i, 1, 0, 0, 0);
        step(0, 20, 21, 1, 20, 77, 1, 0, 1, 1);
        idle_read(20, 21);
        step(0, 22, 20, 1, 22, 88, 0, 0, 1, 3);
        idle_read(22, 20);

        // reset during restore with a full queue
        for (int i = 0; i < 4; i++) step(0, 1, 2, 1, 1 + i, 30 + i, 1, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0, 1, 2);
        idle_read(1, 4);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            wa = $urandom_range(0, 31);
            a0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            step($urandom_range(0, 299) == 0, a0, a1,
                 $urandom_range(0, 1) == 1, wa, $urandom_range(0, 127),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3));
        end

        @(posedge clock);
        #2;
        reset = 1'b0; wr_en = 1'b0; ckpt_req = 1'b0; ckpt_release = 1'b0; restore = 1'b0;
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/checkpointed_map_table.md
CHECKPOINTED_MAP_TABLE -- requirements
Module: checkpointed_map_table

Interface
REQ-001 SHALL have parameter PHYS_ADDR_WIDTH, default 7, physical register index width; values below 5 are illegal.
REQ-002 SHALL have parameter READ_PORTS, default 2, number of independent lookup ports.
REQ-003 SHALL have parameter NUM_CKPTS, default 4, checkpoint slots; must be a power of two, at least 2.
REQ-004 SHALL have parameter CKPT_ID_WIDTH, default 2, equal to log2(NUM_CKPTS).
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port rd_arch_addr  input  READ_PORTS*5  packed lookup addresses, port k at bits [5k+4:5k].
REQ-008 SHALL have port rd_phys_addr  output  READ_PORTS*PHYS_ADDR_WIDTH  packed combinational lookup results, same packing order.
REQ-009 SHALL have port wr_en  input  1  rename write request.
REQ-010 SHALL have port wr_arch_addr  input  5  architectural register being renamed.
REQ-011 SHALL have port wr_phys_addr  input  PHYS_ADDR_WIDTH  new physical mapping.
REQ-012 SHALL have port wr_old_phys  output  PHYS_ADDR_WIDTH  combinational current mapping of wr_arch_addr, for freeing at retire.
REQ-013 SHALL have port ckpt_req  input  1  allocate a checkpoint this cycle.
REQ-014 SHALL have port ckpt_ready  output  1  high when at least one slot is free.
REQ-015 SHALL have port ckpt_id  output  CKPT_ID_WIDTH  slot that ckpt_req allocates this cycle (tail pointer).
REQ-016 SHALL have port ckpt_release  input  1  free the oldest live checkpoint.
REQ-017 SHALL have port restore  input  1  mispredict recovery request.
REQ-018 SHALL have port restore_id  input  CKPT_ID_WIDTH  checkpoint to restore.
REQ-019 SHALL have port ckpt_count  output  CKPT_ID_WIDTH+1  number of live checkpoints.

Function
REQ-020 SHALL hold 32 map entries; entry 0 is never written and always reads 0.
REQ-021 SHALL return rd_phys_addr = map[rd_arch_addr] combinationally, zero-cycle latency; wr_old_phys likewise.
REQ-022 SHALL, on wr_en with wr_arch_addr != 0 and no restore, set map[wr_arch_addr] = wr_phys_addr at the clock edge; wr_arch_addr == 0 is a no-op.
REQ-023 SHALL manage checkpoints as a circular queue: head = oldest live, tail = next to allocate, count 0..NUM_CKPTS; pointers wrap modulo NUM_CKPTS.
REQ-024 SHALL drive ckpt_ready = (count != NUM_CKPTS).
REQ-025 SHALL, on ckpt_req with ckpt_ready and no restore, copy the post-write map (including same-cycle wr_en write) into slot tail, advance tail, increment count.
REQ-026 SHALL ignore ckpt_req when count == NUM_CKPTS; no state change.
REQ-027 SHALL, on ckpt_release with count != 0 and no restore, advance head and decrement count; release at count 0 is ignored.
REQ-028 SHALL treat restore_id as live when its distance from head (modulo NUM_CKPTS) is less than count.
REQ-029 SHALL, on restore with live restore_id, load map from slot restore_id, set tail = restore_id, set count = distance(head, restore_id), freeing that slot and all younger.
REQ-030 SHALL ignore restore with a non-live restore_id entirely.
REQ-031 SHALL give a valid restore priority: same-cycle wr_en, ckpt_req and ckpt_release are discarded.
REQ-032 SHALL apply simultaneous ckpt_req and ckpt_release together when both are legal (count unchanged, head and tail both advance); when count == NUM_CKPTS, ckpt_req is still refused that cycle.

Reset
REQ-033 SHALL, on reset, set map[i] = i for i = 0..31, head = tail = 0, count = 0; outputs then read ckpt_ready = 1, ckpt_id = 0, ckpt_count = 0, rd_phys_addr = identity of rd_arch_addr.
REQ-034 SHALL give reset priority over every other input, including mid-restore or with a full checkpoint queue; checkpoint slot contents need not be cleared.

Configuration
REQ-035 SHALL honour macro MAP_TABLE_BYPASS_EN: when defined, a read port or wr_old_phys... excluded; only rd_phys_addr port k returns wr_phys_addr when wr_en, no restore, wr_arch_addr != 0 and rd_arch_addr[k] == wr_arch_addr.
REQ-036 SHALL, without MAP_TABLE_BYPASS_EN, return the pre-write stored mapping on all read ports; wr_old_phys always returns the pre-write mapping in both builds.

Verification
REQ-037 SHALL cover: reset, read x5 and x31 -> 5 and 31; write x0 = 40 -> x0 still reads 0.
REQ-038 SHALL cover: wr x3 = 64 with read port 0 on x3 same cycle -> 3 without macro, 64 with macro; wr_old_phys = 3; next cycle 64.
REQ-039 SHALL cover: ckpt_req with wr x7 = 90 same cycle (id 0), then wr x7 = 91, restore id 0 -> x7 reads 90, count 0.
REQ-040 SHALL cover: four ckpt_req -> ids 0,1,2,3, ckpt_ready 0; fifth refused; release -> count 3, next allocation id 0 (wrap).
REQ-041 SHALL cover: ids 0..2 live, restore id 1 with same-cycle wr_en and ckpt_req -> map = slot 1, count 1, tail 1, write and alloc discarded; restore id 3 then ignored.
REQ-042 SHALL cover: reset asserted during restore with count 4 -> identity map, count 0, ckpt_ready 1.
